mul_unit_pipe: RTL and testbench

- Fully pipelined integer multiply functional unit for the out-of-order core; successor to the single-in-flight sequential multiplier.
- Accepts one RV32M multiply op (MUL/MULH/MULHSU/MULHU) per cycle from the multiply reservation station and carries up to STAGES ops in flight.
- Drives a CDB request port with backpressure (stall) and supports a global pipeline flush on mispredict.
- Operand width, pipeline depth and tag widths are parameters.

---
 rtl/rv32i_types.sv | 31 +++
 rtl/mul_unit_pipe.sv | 119 +++++++++++
 tb/tb_mul_unit_pipe.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 core types: multiply op encodings, tag widths and the
// default multiply-pipeline stage layout.
package rv32i_types;

   typedef enum logic [2:0] {
      MULT_MUL    = 3'b000,
      MULT_MULH   = 3'b001,
      MULT_MULHSU = 3'b010,
      MULT_MULHU  = 3'b011
   } mult_op_t;

   localparam int MULT_STAGES_DEFAULT = 3;
   localparam int XLEN                = 32;
   localparam int RS_ROB_IDX_W        = 5;
   localparam int CDB_PREG_W          = 6;
   localparam int ARCH_REG_W          = 5;

   // Stage layout at the default core widths; the unit itself builds an
   // equivalent layout from its own parameters.
   typedef struct packed {
      logic                    valid;
      mult_op_t                op;
      logic [RS_ROB_IDX_W-1:0] rob_id;
      logic [ARCH_REG_W-1:0]   rd;
      logic [CDB_PREG_W-1:0]   pd;
      logic [XLEN-1:0]         a;
      logic [XLEN-1:0]         b;
      logic [2*XLEN-1:0]       product;
   } mul_stage_t;

endpackage

// File: rtl/mul_unit_pipe.sv
// Fully pipelined RV32M multiply unit: one op per cycle in, fixed STAGES
// latency to a CDB request slot, global stall and flush.
module mul_unit_pipe
   import rv32i_types::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = MULT_STAGES_DEFAULT,
   parameter int ROB_IDX_W  = RS_ROB_IDX_W,
   parameter int PREG_W     = CDB_PREG_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [ROB_IDX_W-1:0]  in_rob_id,
   input  logic [4:0]            in_rd,
   input  logic [PREG_W-1:0]     in_pd,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [ROB_IDX_W-1:0]  out_rob_id,
   output logic [4:0]            out_rd,
   output logic [PREG_W-1:0]     out_pd,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   input  logic                  stall
);

   localparam int W = DATA_WIDTH;

   typedef struct packed {
      mult_op_t             op;
      logic [ROB_IDX_W-1:0] rob_id;
      logic [4:0]           rd;
      logic [PREG_W-1:0]    pd;
      logic [W-1:0]         a;
      logic [W-1:0]         b;
      logic [2*W-1:0]       product;
   } stage_t;

   // Handshake: in_valid/in_ready transfer on a rising edge when both are
   // high; out_valid is consumed by the CDB when out_valid & ~stall. The
   // whole pipe moves in lockstep, so in_ready is simply "the pipe advances".
   logic         stg_valid [STAGES];
   stage_t       stg       [STAGES];
   logic         advance;
   logic         sign_a;
   logic         sign_b;
   logic [2*W+1:0] ext_a;
   logic [2*W+1:0] ext_b;
   logic [2*W+1:0] prod;
   logic [1:0]     unused_prod_hi;

   assign advance  = ~(stg_valid[STAGES-1] & stall);
   assign in_ready = advance;

   // Operands go out to 2W+2 bits so the low 2W+2 bits of an unsigned
   // multiply equal the signed (W+1)x(W+1) product.
   always_comb begin
      sign_a = (in_op == MULT_MUL) || (in_op == MULT_MULH) || (in_op == MULT_MULHSU);
      sign_b = (in_op == MULT_MUL) || (in_op == MULT_MULH);
      ext_a  = {{(W+2){sign_a & in_a[W-1]}}, in_a};
      ext_b  = {{(W+2){sign_b & in_b[W-1]}}, in_b};
      prod   = ext_a * ext_b;
   end

   assign unused_prod_hi = prod[2*W+1:2*W];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         stg_valid[0] <= 1'b0;
      end else if (advance) begin
         stg_valid[0] <= in_valid;
      end
      if (advance) begin
         stg[0].op      <= mult_op_t'(in_op);
         stg[0].rob_id  <= in_rob_id;
         stg[0].rd      <= in_rd;
         stg[0].pd      <= in_pd;
         stg[0].a       <= in_a;
         stg[0].b       <= in_b;
         stg[0].product <= prod[2*W-1:0];
      end
   end

   for (genvar i = 1; i < STAGES; i++) begin : g_stage
      always_ff @(posedge clk) begin
         if (rst || flush) begin
            stg_valid[i] <= 1'b0;
         end else if (advance) begin
            stg_valid[i] <= stg_valid[i-1];
         end
         if (advance) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign out_valid  = stg_valid[STAGES-1];
   assign out_rob_id = stg[STAGES-1].rob_id;
   assign out_rd     = stg[STAGES-1].rd;
   assign out_pd     = stg[STAGES-1].pd;
   assign out_a      = stg[STAGES-1].a;
   assign out_b      = stg[STAGES-1].b;

   // Undefined funct3 codes retire with a zero result.
   always_comb begin
      out_result = '0;
      case (stg[STAGES-1].op)
         MULT_MUL:                           out_result = stg[STAGES-1].product[W-1:0];
         MULT_MULH, MULT_MULHSU, MULT_MULHU: out_result = stg[STAGES-1].product[2*W-1:W];
         default:                            out_result = '0;
      endcase
   end

endmodule

// File: tb/tb_mul_unit_pipe.sv
// Directed bench for mul_unit_pipe at the default shape, plus random sweeps
// on a 16-bit/1-stage and a 32-bit/5-stage instance against a reference model.
module tb_mul_unit_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   int pass_cnt = 0;
   int total_cnt = 0;

   // ---------------- main DUT (32-bit, 3 stages) ----------------
   logic        flush = 1'b0, in_valid = 1'b0, stall = 1'b0, in_ready, out_valid;
   logic [2:0]  in_op = '0;
   logic [31:0] in_a = '0, in_b = '0, out_result, out_a, out_b;
   logic [4:0]  in_rob_id = '0, in_rd = '0, out_rob_id, out_rd;
   logic [5:0]  in_pd = '0, out_pd;

   mul_unit_pipe #(.DATA_WIDTH(32), .STAGES(3), .ROB_IDX_W(5), .PREG_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rob_id(in_rob_id), .in_rd(in_rd),
      .in_pd(in_pd), .out_valid(out_valid), .out_result(out_result),
      .out_rob_id(out_rob_id), .out_rd(out_rd), .out_pd(out_pd), .out_a(out_a),
      .out_b(out_b), .stall(stall)
   );

   // ---------------- sweep DUT: 16-bit, 1 stage ----------------
   logic        s1_in_valid = 1'b0, s1_in_ready, s1_out_valid;
   logic [2:0]  s1_in_op = '0;
   logic [15:0] s1_in_a = '0, s1_in_b = '0, s1_out_result, s1_out_a, s1_out_b;
   logic [4:0]  s1_in_rob_id = '0, s1_out_rob_id, s1_out_rd;
   logic [5:0]  s1_out_pd;

   mul_unit_pipe #(.DATA_WIDTH(16), .STAGES(1), .ROB_IDX_W(5), .PREG_W(6)) dut_s1 (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .in_op(s1_in_op), .in_a(s1_in_a), .in_b(s1_in_b), .in_rob_id(s1_in_rob_id),
      .in_rd(5'd1), .in_pd(6'd1), .out_valid(s1_out_valid), .out_result(s1_out_result),
      .out_rob_id(s1_out_rob_id), .out_rd(s1_out_rd), .out_pd(s1_out_pd),
      .out_a(s1_out_a), .out_b(s1_out_b), .stall(1'b0)
   );

   // ---------------- sweep DUT: 32-bit, 5 stages ----------------
   logic        s5_in_valid = 1'b0, s5_in_ready, s5_out_valid;
   logic [2:0]  s5_in_op = '0;
   logic [31:0] s5_in_a = '0, s5_in_b = '0, s5_out_result, s5_out_a, s5_out_b;
   logic [4:0]  s5_in_rob_id = '0, s5_out_rob_id, s5_out_rd;
   logic [5:0]  s5_out_pd;

   mul_unit_pipe #(.DATA_WIDTH(32), .STAGES(5), .ROB_IDX_W(5), .PREG_W(6)) dut_s5 (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s5_in_valid), .in_ready(s5_in_ready),
      .in_op(s5_in_op), .in_a(s5_in_a), .in_b(s5_in_b), .in_rob_id(s5_in_rob_id),
      .in_rd(5'd2), .in_pd(6'd2), .out_valid(s5_out_valid), .out_result(s5_out_result),
      .out_rob_id(s5_out_rob_id), .out_rd(s5_out_rd), .out_pd(s5_out_pd),
      .out_a(s5_out_a), .out_b(s5_out_b), .stall(1'b0)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q1[$];
   logic [4:0]  rob_q1[$];
   int          due_q1[$];
   logic [31:0] exp_q5[$];
   logic [4:0]  rob_q5[$];
   int          due_q5[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: value-level sign handling in 66-bit arithmetic.
   function automatic logic [31:0] ref_mul(input int w, input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        mask, am, bm;
      logic signed [65:0] ea, eb, p, sh;
      logic               sa, sb;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      am = a & mask;
      bm = b & mask;
      sa = (op == 3'd0 || op == 3'd1 || op == 3'd2) && am[w-1];
      sb = (op == 3'd0 || op == 3'd1) && bm[w-1];
      ea = $signed({34'd0, am});
      eb = $signed({34'd0, bm});
      if (sa) ea = ea - (66'sd1 <<< w);
      if (sb) eb = eb - (66'sd1 <<< w);
      p  = ea * eb;
      sh = p >>> w;
      case (op)
         3'd0:             return p[31:0] & mask;
         3'd1, 3'd2, 3'd3: return sh[31:0] & mask;
         default:          return 32'd0;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      cyc++;
      #2;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rob);
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_rob_id = rob;
      in_rd     = rob + 5'd3;
      in_pd     = {1'b1, rob};
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] res, input logic [4:0] rob);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_result"}, out_result, res);
      chk({tag, "_rob"}, 32'(out_rob_id), 32'(rob));
      chk({tag, "_rd"}, 32'(out_rd), 32'(rob + 5'd3));
      chk({tag, "_pd"}, 32'(out_pd), 32'({1'b1, rob}));
   endtask

   task automatic sweep_check();
      if (due_q1.size() > 0 && due_q1[0] == cyc) begin
         chk("s1_valid", 32'(s1_out_valid), 32'd1);
         chk("s1_result", 32'(s1_out_result), exp_q1.pop_front());
         chk("s1_rob", 32'(s1_out_rob_id), 32'(rob_q1.pop_front()));
         void'(due_q1.pop_front());
      end else begin
         chk("s1_idle", 32'(s1_out_valid), 32'd0);
      end
      if (due_q5.size() > 0 && due_q5[0] == cyc) begin
         chk("s5_valid", 32'(s5_out_valid), 32'd1);
         chk("s5_result", s5_out_result, exp_q5.pop_front());
         chk("s5_rob", 32'(s5_out_rob_id), 32'(rob_q5.pop_front()));
         void'(due_q5.pop_front());
      end else begin
         chk("s5_idle", 32'(s5_out_valid), 32'd0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // MUL 7 * -3, latency STAGES-1 edges after accept
      drive(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1);
      tick();
      idle();
      chk("mul_lat0", 32'(out_valid), 32'd0);
      tick();
      chk("mul_lat1", 32'(out_valid), 32'd0);
      tick();
      chk_out("mul", 32'hFFFF_FFEB, 5'd1);
      tick();
      chk("mul_after", 32'(out_valid), 32'd0);

      // back-to-back high-half ops
      drive(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2);
      tick();
      drive(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      tick();
      drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
      tick();
      idle();
      chk_out("mulh", 32'h4000_0000, 5'd2);
      tick();
      chk_out("mulhsu", 32'hFFFF_FFFF, 5'd3);
      tick();
      chk_out("mulhu", 32'hFFFF_FFFE, 5'd4);
      tick();
      chk("b2b_after", 32'(out_valid), 32'd0);

      // stall with an empty output slot does not block
      stall = 1'b1;
      #1;
      chk("stall_empty_ready", 32'(in_ready), 32'd1);
      stall = 1'b0;

      // fill, then stall for 4 cycles
      drive(3'b000, 32'd3, 32'd5, 5'd5);
      tick();
      drive(3'b000, 32'd100, 32'd200, 5'd6);
      tick();
      drive(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd7);
      stall = 1'b1;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk_out("stall_hold", 32'd15, 5'd5);
         chk("stall_a", out_a, 32'd3);
         tick();
      end
      stall = 1'b0;
      #1;
      chk("release_ready", 32'(in_ready), 32'd1);
      chk_out("drain0", 32'd15, 5'd5);
      tick();
      chk_out("drain1", 32'd20000, 5'd6);
      tick();
      chk_out("drain2", 32'd1, 5'd7);
      tick();
      chk("drain_after", 32'(out_valid), 32'd0);

      // flush with three in flight and a new request in the same cycle
      drive(3'b000, 32'd2, 32'd2, 5'd9);
      tick();
      drive(3'b000, 32'd3, 32'd3, 5'd10);
      tick();
      drive(3'b000, 32'd4, 32'd4, 5'd11);
      tick();
      chk_out("preflush", 32'd4, 5'd9);
      drive(3'b000, 32'd5, 32'd5, 5'd12);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) begin
         chk("flush_empty", 32'(out_valid), 32'd0);
         tick();
      end
      drive(3'b000, 32'd6, 32'd7, 5'd13);
      tick();
      idle();
      tick();
      tick();
      chk_out("postflush", 32'd42, 5'd13);
      tick();
      chk("postflush_after", 32'(out_valid), 32'd0);

      // reset mid-stream
      drive(3'b000, 32'd8, 32'd8, 5'd14);
      tick();
      drive(3'b000, 32'd9, 32'd9, 5'd15);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_quiet", 32'(out_valid), 32'd0);
      end

      // undefined funct3 retires a zero result with normal timing
      drive(3'b100, 32'd5, 32'd6, 5'd16);
      tick();
      idle();
      tick();
      chk("undef_early", 32'(out_valid), 32'd0);
      tick();
      chk_out("undef", 32'd0, 5'd16);

      // random sweep on the 16b/1-stage and 32b/5-stage instances
      for (int n = 0; n < 60; n++) begin
         logic v1, v5;
         v1 = ($urandom_range(0, 3) != 0);
         v5 = ($urandom_range(0, 3) != 0);
         s1_in_valid  = v1;
         s1_in_op     = 3'($urandom_range(0, 7));
         s1_in_a      = 16'($urandom);
         s1_in_b      = 16'($urandom);
         s1_in_rob_id = 5'(n);
         s5_in_valid  = v5;
         s5_in_op     = 3'($urandom_range(0, 7));
         s5_in_a      = (n % 7 == 0) ? 32'h8000_0000 : $urandom;
         s5_in_b      = (n % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
         s5_in_rob_id = 5'(n);
         tick();
         if (v1) begin
            exp_q1.push_back(ref_mul(16, s1_in_op, {16'd0, s1_in_a}, {16'd0, s1_in_b}));
            rob_q1.push_back(s1_in_rob_id);
            due_q1.push_back(cyc + 0);
         end
         if (v5) begin
            exp_q5.push_back(ref_mul(32, s5_in_op, s5_in_a, s5_in_b));
            rob_q5.push_back(s5_in_rob_id);
            due_q5.push_back(cyc + 4);
         end
         sweep_check();
      end
      s1_in_valid = 1'b0;
      s5_in_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         sweep_check();
      end
      chk("s1_drained", 32'(exp_q1.size()), 32'd0);
      chk("s5_drained", 32'(exp_q5.size()), 32'd0);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
